fc_layer_sequencer: RTL

Controller that sequences one fully-connected layer pass through the row-addressed weight memory. On `start` it latches an input activation vector. It then walks the memory address from row 0 to row INPUT_NODES-1, accounting for the memory's one-cycle registered read. Each activation byte is presented to the downstream MAC array aligned with the matching weight row, with stall support via `mac_ready`. It sits between the layer-level control FSM and the weight memory / MAC array pair.

---
 rtl/fc_layer_sequencer.sv | 62 ++++++
 1 files changed

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: walks weight rows 0..INPUT_NODES-1 and streams aligned activation beats to a MAC array
module fc_layer_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int INPUT_NODES = 128,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH*INPUT_NODES-1:0] in_vec,
  input  logic                              mac_ready,
  output logic [ADDR_WIDTH-1:0]             w_addr,
  output logic [DATA_WIDTH-1:0]             act,
  output logic                              act_valid,
  output logic                              acc_clear,
  output logic                              last,
  output logic                              busy,
  output logic                              done
);
  localparam int VW = DATA_WIDTH * INPUT_NODES;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(INPUT_NODES - 1);
  logic [1:0]          state_q, state_d;
  logic [ADDR_WIDTH:0] idx_q, idx_d, idx_inc;
  logic [VW-1:0]       vec_q, vec_d;
  logic                at_last, advance;
  // The latched vector shifts left on every accepted beat, so the current element is always the top slice.
  always_comb begin
    at_last = idx_q == LAST_IDX;
    idx_inc = idx_q + (ADDR_WIDTH+1)'(1);
    advance = state_q == RUN && mac_ready && !at_last;
    state_d = state_q == IDLE ? (start ? PRIME : IDLE) :
              state_q == PRIME ? RUN :
              state_q == RUN ? (mac_ready && at_last ? DONE : RUN) : IDLE;
    idx_d = state_q == IDLE ? '0 : advance ? idx_inc : idx_q;
    vec_d = state_q == IDLE && start ? in_vec : advance ? vec_q << DATA_WIDTH : vec_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end
  // Holding the address on a stall re-reads the same row so weights stay aligned with act.
  always_comb begin
    w_addr    = state_q == RUN ? (advance ? idx_inc[ADDR_WIDTH-1:0] : idx_q[ADDR_WIDTH-1:0]) : '0;
    act_valid = state_q == RUN;
    act       = act_valid ? vec_q[VW-1 -: DATA_WIDTH] : '0;
    acc_clear = act_valid && idx_q == '0;
    last      = act_valid && at_last;
    busy      = state_q != IDLE;
    done      = state_q == DONE;
  end
endmodule
